// File: rtl/audio_level_sampler.sv
// rtl/audio_level_sampler.sv - block-average magnitude sampler with interrupt handshake
module audio_level_sampler #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int AVG_LOG2     = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    interrupt_ack,
  output logic [7:0]              input_data,
  output logic                    interrupt_event,
  output logic                    data_pending,
  output logic                    overrun
);

  localparam int MW = SAMPLE_WIDTH - 1;
  localparam int AW = MW + AVG_LOG2;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]          data_q, data_d;
  logic                event_q, event_d;
  logic                overrun_q, overrun_d;

  logic [SAMPLE_WIDTH-1:0] neg_s;
  logic [MW-1:0]           mag;
  logic [AW-1:0]           sum;
  logic                    block_done;

  // Negating the most negative code leaves its sign bit set; saturate that case.
  always_comb begin
    neg_s = ~sample_data + 1'b1;
    if (!sample_data[SAMPLE_WIDTH-1])
      mag = sample_data[MW-1:0];
    else if (neg_s[SAMPLE_WIDTH-1])
      mag = {MW{1'b1}};
    else
      mag = neg_s[MW-1:0];
  end

  assign sum        = acc_q + {{AVG_LOG2{1'b0}}, mag};
  assign block_done = sample_valid && (cnt_q == {AVG_LOG2{1'b1}});

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    event_d   = block_done;
    overrun_d = overrun_q;
    state_d   = state_q;
    if (sample_valid) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = block_done ? '0 : sum;
    end
    // Shifting sum by AVG_LOG2 and taking avg[MW-1 -: 8] is the top byte of sum.
    if (block_done)
      data_d = sum[AW-1 -: 8];
    case (state_q)
      IDLE: begin
        if (block_done) state_d = PENDING;
      end
      PENDING: begin
        if (block_done) begin
          state_d = PENDING;
          if (!interrupt_ack) overrun_d = 1'b1;
        end else if (interrupt_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      event_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      event_q   <= event_d;
      overrun_q <= overrun_d;
    end
  end

  assign input_data      = data_q;
  assign interrupt_event = event_q;
  assign data_pending    = (state_q == PENDING);
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_audio_level_sampler.sv
// tb/tb_audio_level_sampler.sv - directed self-checking bench for audio_level_sampler
module tb_audio_level_sampler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        interrupt_ack = 1'b0;
  logic [7:0]  input_data;
  logic        interrupt_event;
  logic        data_pending;
  logic        overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  audio_level_sampler #(.SAMPLE_WIDTH(16), .AVG_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .interrupt_ack(interrupt_ack), .input_data(input_data), .interrupt_event(interrupt_event),
    .data_pending(data_pending), .overrun(overrun)
  );

  task automatic do_reset();
    reset_n = 1'b0; sample_valid = 1'b0; interrupt_ack = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] v, input logic ack);
    sample_valid = 1'b1; sample_data = v; interrupt_ack = ack;
    @(posedge clk); #1;
    sample_valid = 1'b0; interrupt_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_ack();
    interrupt_ack = 1'b1;
    @(posedge clk); #1;
    interrupt_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; #2;
    total_cnt++; if (input_data !== 8'h00) $display("FAIL reset_data got %h exp 00", input_data); else pass_cnt++;
    total_cnt++; if (interrupt_event !== 1'b0) $display("FAIL reset_event got %b exp 0", interrupt_event); else pass_cnt++;
    total_cnt++; if (data_pending !== 1'b0) $display("FAIL reset_pending got %b exp 0", data_pending); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) send(16'h4000, 1'b0);
    total_cnt++; if (interrupt_event !== 1'b0) $display("FAIL basic_early_event got %b exp 0", interrupt_event); else pass_cnt++;
    send(16'h4000, 1'b0);
    total_cnt++; if (input_data !== 8'h80) $display("FAIL basic_data got %h exp 80", input_data); else pass_cnt++;
    total_cnt++; if (interrupt_event !== 1'b1) $display("FAIL basic_event got %b exp 1", interrupt_event); else pass_cnt++;
    total_cnt++; if (data_pending !== 1'b1) $display("FAIL basic_pending got %b exp 1", data_pending); else pass_cnt++;
    idle(1);
    total_cnt++; if (interrupt_event !== 1'b0) $display("FAIL basic_event_width got %b exp 0", interrupt_event); else pass_cnt++;
    total_cnt++; if (input_data !== 8'h80) $display("FAIL basic_data_hold got %h exp 80", input_data); else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    send(16'h8000, 1'b0); send(16'h8000, 1'b0); send(16'h7FFF, 1'b0); send(16'h8001, 1'b0);
    total_cnt++; if (input_data !== 8'hFF) $display("FAIL sat_data got %h exp FF", input_data); else pass_cnt++;
    do_reset();
    send(16'h0064, 1'b0); send(16'hFF9C, 1'b0); send(16'h012C, 1'b0); send(16'hFED4, 1'b0);
    total_cnt++; if (input_data !== 8'h01) $display("FAIL sign_data got %h exp 01", input_data); else pass_cnt++;
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(16'h4000, 1'b0);
      idle($urandom_range(0, 5));
    end
    total_cnt++; if (data_pending !== 1'b0) $display("FAIL gaps_early_pending got %b exp 0", data_pending); else pass_cnt++;
    send(16'h4000, 1'b0);
    total_cnt++; if (input_data !== 8'h80) $display("FAIL gaps_data got %h exp 80", input_data); else pass_cnt++;
    total_cnt++; if (interrupt_event !== 1'b1) $display("FAIL gaps_event got %b exp 1", interrupt_event); else pass_cnt++;
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h4000, 1'b0);
    send(16'h7FFF, 1'b0); send(16'h7FFF, 1'b0);
    #2 reset_n = 1'b0; #1;
    total_cnt++; if (input_data !== 8'h00) $display("FAIL midrst_data got %h exp 00", input_data); else pass_cnt++;
    total_cnt++; if (data_pending !== 1'b0) $display("FAIL midrst_pending got %b exp 0", data_pending); else pass_cnt++;
    @(posedge clk); #1; reset_n = 1'b1;
    send(16'h0800, 1'b0); send(16'h0800, 1'b0);
    total_cnt++; if (data_pending !== 1'b0) $display("FAIL midrst_stale_block got %b exp 0", data_pending); else pass_cnt++;
    send(16'h0800, 1'b0); send(16'h0800, 1'b0);
    total_cnt++; if (input_data !== 8'h10) $display("FAIL midrst_data_after got %h exp 10", input_data); else pass_cnt++;
    total_cnt++; if (data_pending !== 1'b1) $display("FAIL midrst_pending_after got %b exp 1", data_pending); else pass_cnt++;
  endtask

  task automatic test_ack();
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h4000, 1'b0);
    idle(10);
    total_cnt++; if (data_pending !== 1'b1) $display("FAIL ack_pending_before got %b exp 1", data_pending); else pass_cnt++;
    pulse_ack();
    total_cnt++; if (data_pending !== 1'b0) $display("FAIL ack_pending_clear got %b exp 0", data_pending); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL ack_overrun got %b exp 0", overrun); else pass_cnt++;
    pulse_ack();
    total_cnt++; if (data_pending !== 1'b0) $display("FAIL ack_idle_ignored got %b exp 0", data_pending); else pass_cnt++;
    for (int i = 0; i < 4; i++) send(16'h2000, 1'b0);
    total_cnt++; if (data_pending !== 1'b1) $display("FAIL ack_next_pending got %b exp 1", data_pending); else pass_cnt++;
    total_cnt++; if (input_data !== 8'h40) $display("FAIL ack_next_data got %h exp 40", input_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h4000, 1'b0);
    total_cnt++; if (interrupt_event !== 1'b1) $display("FAIL b2b_event1 got %b exp 1", interrupt_event); else pass_cnt++;
    send(16'h1000, 1'b0);
    total_cnt++; if (interrupt_event !== 1'b0) $display("FAIL b2b_event_gap got %b exp 0", interrupt_event); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun_early got %b exp 0", overrun); else pass_cnt++;
    for (int i = 0; i < 3; i++) send(16'h1000, 1'b0);
    total_cnt++; if (interrupt_event !== 1'b1) $display("FAIL b2b_event2 got %b exp 1", interrupt_event); else pass_cnt++;
    total_cnt++; if (input_data !== 8'h20) $display("FAIL b2b_data got %h exp 20", input_data); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b1) $display("FAIL b2b_overrun got %b exp 1", overrun); else pass_cnt++;
    pulse_ack();
    total_cnt++; if (data_pending !== 1'b0) $display("FAIL b2b_ack_pending got %b exp 0", data_pending); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b1) $display("FAIL b2b_overrun_sticky got %b exp 1", overrun); else pass_cnt++;
  endtask

  task automatic test_simultaneous_ack();
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h4000, 1'b0);
    for (int i = 0; i < 3; i++) send(16'h3000, 1'b0);
    send(16'h3000, 1'b1);
    total_cnt++; if (data_pending !== 1'b1) $display("FAIL simul_pending got %b exp 1", data_pending); else pass_cnt++;
    total_cnt++; if (interrupt_event !== 1'b1) $display("FAIL simul_event got %b exp 1", interrupt_event); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL simul_overrun got %b exp 0", overrun); else pass_cnt++;
    total_cnt++; if (input_data !== 8'h60) $display("FAIL simul_data got %h exp 60", input_data); else pass_cnt++;
    pulse_ack();
    total_cnt++; if (data_pending !== 1'b0) $display("FAIL simul_final_ack got %b exp 0", data_pending); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_gaps();
    test_reset_mid_block();
    test_ack();
    test_back_to_back();
    test_simultaneous_ack();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/audio_level_sampler.md
# audio_level_sampler

Upstream feeder for the PicoBlaze LED level-meter controller. Reduces the signed audio sample stream to one 8-bit average-magnitude value per block of 2^AVG_LOG2 samples. Presents that value on `input_data` (PicoBlaze input port 0x00) and raises `interrupt_event` once per block. Tracks the CPU's interrupt acknowledge so missed blocks are flagged.

## Interface

Parameters:
- `SAMPLE_WIDTH`, default 16: width of the signed two's-complement input sample.
- `AVG_LOG2`, default 8: log2 of the block length; 256 samples per block by default.

Ports:
- `clk`  input  1  system clock; all logic is in this single clock domain.
- `reset_n`  input  1  asynchronous, active-low reset.
- `sample_valid`  input  1  one-cycle qualifier for `sample_data`; may be high on consecutive cycles.
- `sample_data`  input  SAMPLE_WIDTH  signed audio sample.
- `interrupt_ack`  input  1  acknowledge from the processor; level or pulse, sampled on `clk`.
- `input_data`  output  8  latest block average, `avg[SAMPLE_WIDTH-2 -: 8]`; holds its value between blocks.
- `interrupt_event`  output  1  one-cycle pulse per completed block.
- `data_pending`  output  1  block presented and not yet acknowledged.
- `overrun`  output  1  sticky flag; set when a block completes while `data_pending` is still 1.

## Operation

- Magnitude:
  - `mag = |sample_data|`, width SAMPLE_WIDTH-1.
  - The most negative input saturates to `2^(SAMPLE_WIDTH-1)-1`; for example, -32768 becomes 32767.
- Accumulator:
  - Width is SAMPLE_WIDTH-1+AVG_LOG2. It cannot overflow.
  - Sample counter is AVG_LOG2 bits wide.
- On each `sample_valid`:
  - If the counter is not all-ones: `acc += mag` and the counter increments.
  - If the counter is all-ones (last sample of the block): `avg = (acc + mag) >> AVG_LOG2`. Then register `input_data`, clear `acc` to 0, and wrap the counter to 0.
  - The next block starts on the very next `sample_valid` with no lost samples.
- Handshake FSM, two states:
  - IDLE → PENDING on block completion. `interrupt_event` pulses and `data_pending` becomes 1.
  - PENDING → IDLE on `interrupt_ack` high with no simultaneous completion.
  - PENDING + completion without ack: stay in PENDING, overwrite `input_data` with the newest value, pulse `interrupt_event` again, and set `overrun`.
  - PENDING + completion + ack in the same cycle: stay in PENDING, pulse `interrupt_event`, and do not set `overrun`. The ack retires the old block.
  - IDLE + ack: ignored.
- `overrun` clears only on reset.
- `sample_valid` low: the accumulator and counter hold.

## Timing

- Reset (asynchronous assert, synchronous release): `input_data`=0, `interrupt_event`=0, `data_pending`=0, `overrun`=0, `acc`=0, counter=0, FSM=IDLE.
- Reset mid-block discards the partial accumulation. The first block after reset is a full 2^AVG_LOG2 samples.
- Latency: the final `sample_valid` at edge t produces the new `input_data`, `interrupt_event`=1 and `data_pending`=1 all after edge t+1. All three are registered outputs.
- `interrupt_event` is high for exactly one cycle per completed block, including back-to-back completions.
- `input_data` is stable from the same cycle as `interrupt_event` until the next completion. The processor's registered input mux may therefore sample it any time before the next block.
- `interrupt_ack` at edge t clears `data_pending` after edge t+1.
- Throughput: one sample per clock. Minimum spacing between events is 2^AVG_LOG2 cycles.

## Test plan

- **Basic average:** AVG_LOG2=2; samples 0x4000 ×4 on consecutive cycles.
  - `input_data`=0x80 one cycle after the 4th sample.
  - `interrupt_event` high for one cycle; `data_pending`=1.
- **Sign and saturation:** AVG_LOG2=2; samples -32768, -32768, 32767, -32767.
  - avg=32767, so `input_data`=0xFF.
  - Samples 100, -100, 300, -300: avg=200, so `input_data`=0x01.
- **Gaps and reset:**
  - Four samples with random 0–5 idle cycles between them: same result as back-to-back.
  - Assert `reset_n`=0 after 2 samples: all outputs 0. The next full block averages only post-reset samples.
- **Acknowledge:** block completes, `interrupt_ack` pulses 10 cycles later.
  - `data_pending` falls one cycle after the ack.
  - `overrun` stays 0.
  - The next block raises `data_pending` again.
- **Overrun:** two blocks with no ack.
  - Second `interrupt_event` pulses.
  - `input_data` equals the second average.
  - `overrun`=1 and stays 1 after a later ack.
- **Simultaneous completion and ack:** ack asserted in the same cycle as the completing sample.
  - `data_pending` stays 1, `interrupt_event` pulses, `overrun`=0.
